// File: rtl/bch_correct.sv
// rtl/bch_correct.sv - BCH correction stage: buffers data bits and XORs Chien error flags onto them
module bch_correct #(
  parameter int unsigned M     = 4,
  parameter int unsigned K     = 5,
  parameter int unsigned T     = 3,
  parameter int unsigned WORDS = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     chien_valid_i,
  input  logic                     chien_err_i,
  output logic                     chien_accepted_o,
  output logic                     out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     out_first_o,
  output logic                     out_last_o,
  output logic [$clog2(K+1)-1:0]   out_nerr_o,
  output logic                     out_overflow_o
);

  localparam int unsigned N  = (1 << M) - 1;
  localparam int unsigned D  = K * WORDS;
  localparam int unsigned PW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned CW = $clog2(D + 1);
  localparam int unsigned BW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned NW = $clog2(K + 1);

  if (K == 0 || K >= N || WORDS == 0) begin : g_bad_params
    $error("bch_correct: need 0 < K < 2**M-1 and WORDS >= 1");
  end

  logic [D-1:0]  buf_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic [NW-1:0] acc_q, acc_d;
  logic          rdy_q;

  logic          out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_first_q, out_first_d;
  logic          out_last_q, out_last_d;
  logic [NW-1:0] out_nerr_q, out_nerr_d;
  logic          out_overflow_q, out_overflow_d;

  logic          out_free;
  logic          wr_en;
  logic          rd_en;
  logic          word_end;
  logic [NW-1:0] err_sum;

  // The output register can take a new bit when empty or draining this cycle.
  assign out_free         = !out_valid_q || out_ready_i;
  // rdy_q keeps the input closed for the reset cycle and the one after it.
  assign in_ready_o       = rdy_q && !reset_i && (count_q != CW'(D));
  assign wr_en            = in_valid_i && in_ready_o;
  // A flag is only consumed when there is a buffered bit for it to correct.
  assign rd_en            = chien_valid_i && (count_q != '0) && out_free && !reset_i;
  assign chien_accepted_o = rd_en;
  assign word_end         = (bit_idx_q == BW'(K - 1));
  assign err_sum          = acc_q + NW'(chien_err_i);

  assign out_data_o       = out_data_q;
  assign out_valid_o      = out_valid_q;
  assign out_first_o      = out_first_q;
  assign out_last_o       = out_last_q;
  assign out_nerr_o       = out_nerr_q;
  assign out_overflow_o   = out_overflow_q;

  // Next-state for pointers, fill count, framing index, error tally and output register.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    bit_idx_d      = bit_idx_q;
    acc_d          = acc_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    out_first_d    = out_first_q;
    out_last_d     = out_last_q;
    out_nerr_d     = out_nerr_q;
    out_overflow_d = out_overflow_q;

    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == PW'(D - 1)) ? '0 : wr_ptr_q + PW'(1);
    end

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (rd_en) begin
      rd_ptr_d    = (rd_ptr_q == PW'(D - 1)) ? '0 : rd_ptr_q + PW'(1);
      bit_idx_d   = word_end ? '0 : bit_idx_q + BW'(1);
      out_data_d  = buf_q[rd_ptr_q] ^ chien_err_i;
      out_valid_d = 1'b1;
      out_first_d = (bit_idx_q == '0);
      out_last_d  = word_end;
      if (word_end) begin
        out_nerr_d     = err_sum;
        out_overflow_d = 32'(err_sum) > T;
        acc_d          = '0;
      end else begin
        acc_d = err_sum;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Data storage is not reset; cleared pointers make stale bits unreachable.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      buf_q[wr_ptr_q] <= in_data_i;
    end
  end

  // Control and output registers; reset discards all buffered and partial state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      bit_idx_q      <= '0;
      acc_q          <= '0;
      rdy_q          <= 1'b0;
      out_data_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_first_q    <= 1'b0;
      out_last_q     <= 1'b0;
      out_nerr_q     <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      bit_idx_q      <= bit_idx_d;
      acc_q          <= acc_d;
      rdy_q          <= 1'b1;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      out_first_q    <= out_first_d;
      out_last_q     <= out_last_d;
      out_nerr_q     <= out_nerr_d;
      out_overflow_q <= out_overflow_d;
    end
  end

endmodule

// File: tb/tb_bch_correct.sv
// tb/tb_bch_correct.sv - self-checking bench for bch_correct
module tb_bch_correct;

  localparam int K = 5;
  localparam int T = 3;
  localparam int D = 10;

  logic       clk = 1'b0;
  logic       reset, in_data, in_valid, chien_valid, chien_err, out_ready;
  logic       in_ready, chien_accepted, out_data, out_valid, out_first, out_last, out_overflow;
  logic [2:0] out_nerr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit   wq[$], fq[$], md[$], mf[$];
  logic cap_d[$], cap_f[$], cap_l[$], cap_o[$];
  int   cap_n[$], cap_t[$];
  bit   exp_d[$], exp_f[$], exp_l[$], exp_o[$];
  int   exp_n[$];

  bch_correct #(.M(4), .K(K), .T(T), .WORDS(2)) dut (
    .clk_i(clk), .reset_i(reset),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .chien_valid_i(chien_valid), .chien_err_i(chien_err), .chien_accepted_o(chien_accepted),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_first_o(out_first), .out_last_o(out_last),
    .out_nerr_o(out_nerr), .out_overflow_o(out_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    wq.delete(); fq.delete(); md.delete(); mf.delete();
    cap_d.delete(); cap_f.delete(); cap_l.delete(); cap_o.delete(); cap_n.delete(); cap_t.delete();
  endtask

  task automatic load_data(input int n, input logic [31:0] pat, input bit rnd);
    for (int i = 0; i < n; i++) begin
      bit b;
      b = rnd ? 1'($urandom) : pat[i];
      wq.push_back(b);
      md.push_back(b);
    end
  endtask

  task automatic load_flags(input int n, input logic [31:0] pat, input bit rnd);
    for (int i = 0; i < n; i++) begin
      bit b;
      b = rnd ? 1'($urandom) : pat[i];
      fq.push_back(b);
      mf.push_back(b);
    end
  endtask

  // Reference: each output is data XOR flag; framing and counts follow from position in the stream.
  task automatic build_exp();
    int ones;
    ones = 0;
    exp_d.delete(); exp_f.delete(); exp_l.delete(); exp_o.delete(); exp_n.delete();
    for (int i = 0; i < md.size(); i++) begin
      if (i % K == 0) ones = 0;
      ones += int'(mf[i]);
      exp_d.push_back(md[i] ^ mf[i]);
      exp_f.push_back(i % K == 0);
      exp_l.push_back(i % K == K - 1);
      exp_n.push_back(ones);
      exp_o.push_back(ones > T);
    end
  endtask

  // Drives queued writes and flags, collecting every output handshake.
  task automatic run_engine(input bit rnd, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (wq.size() > 0 || fq.size() > 0 || out_valid === 1'b1) begin
      if (n > 2000) begin
        ok = 1'b0;
        break;
      end
      n++;
      out_ready   = rnd ? ($urandom_range(3) != 0) : 1'b1;
      in_valid    = (wq.size() > 0) && (!rnd || $urandom_range(1) == 1);
      in_data     = (wq.size() > 0) ? wq[0] : 1'b0;
      chien_valid = (fq.size() > 0) && (!rnd || $urandom_range(2) != 0);
      chien_err   = (fq.size() > 0) ? fq[0] : 1'b0;
      #1;
      if (out_valid && out_ready) begin
        cap_d.push_back(out_data); cap_f.push_back(out_first); cap_l.push_back(out_last);
        cap_n.push_back(int'(out_nerr)); cap_o.push_back(out_overflow); cap_t.push_back(cyc);
      end
      if (in_valid && in_ready) void'(wq.pop_front());
      if (chien_valid && chien_accepted) void'(fq.pop_front());
      tick();
    end
    in_valid = 1'b0; chien_valid = 1'b0; chien_err = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 1'b1; chien_valid = 1'b1; chien_err = 1'b1; out_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++;
    if (chien_accepted !== 1'b0) begin errors++; $display("FAIL reset_accepted got %b want 0", chien_accepted); end
    checks++;
    if ({out_valid, out_data, out_first, out_last, out_overflow, out_nerr} !== 8'b0)
      begin errors++; $display("FAIL reset_outputs got v%b d%b f%b l%b o%b n%0d want all 0", out_valid, out_data, out_first, out_last, out_overflow, out_nerr); end
    reset = 1'b0; in_valid = 1'b0; chien_valid = 1'b0; chien_err = 1'b0;
    repeat (2) tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    bit ok;
    clear_all();
    load_data(5, 32'b01101, 1'b0);
    load_flags(5, 32'b10010, 1'b0);
    run_engine(1'b0, ok);
    build_exp();
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout got stuck want drained"); end
    checks++;
    if (cap_d.size() != exp_d.size()) begin errors++; $display("FAIL basic_len got %0d want %0d", cap_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
      checks++;
      if (cap_d[i] !== exp_d[i] || cap_f[i] !== exp_f[i] || cap_l[i] !== exp_l[i] ||
          (exp_l[i] && (cap_n[i] != exp_n[i] || cap_o[i] !== exp_o[i])))
        begin errors++; $display("FAIL basic_bit%0d got d%b f%b l%b n%0d o%b want d%b f%b l%b n%0d o%b", i, cap_d[i], cap_f[i], cap_l[i], cap_n[i], cap_o[i], exp_d[i], exp_f[i], exp_l[i], exp_n[i], exp_o[i]); end
      if (i > 0) begin
        checks++;
        if (cap_t[i] != cap_t[0] + i) begin errors++; $display("FAIL basic_consecutive%0d got cycle %0d want %0d", i, cap_t[i], cap_t[0] + i); end
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_all();
    load_data(5, 32'b00000, 1'b0);
    load_flags(5, 32'b01111, 1'b0);
    run_engine(1'b0, ok);
    build_exp();
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_timeout got stuck want drained"); end
    checks++;
    if (cap_d.size() != exp_d.size()) begin errors++; $display("FAIL ovf_len got %0d want %0d", cap_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
      checks++;
      if (cap_d[i] !== exp_d[i] || cap_f[i] !== exp_f[i] || cap_l[i] !== exp_l[i] ||
          (exp_l[i] && (cap_n[i] != exp_n[i] || cap_o[i] !== exp_o[i])))
        begin errors++; $display("FAIL ovf_bit%0d got d%b f%b l%b n%0d o%b want d%b f%b l%b n%0d o%b", i, cap_d[i], cap_f[i], cap_l[i], cap_n[i], cap_o[i], exp_d[i], exp_f[i], exp_l[i], exp_n[i], exp_o[i]); end
    end
  endtask

  task automatic test_full();
    bit ok, x;
    clear_all();
    load_data(D, 32'b0, 1'b1);
    run_engine(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_fill_timeout got stuck want drained"); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", in_ready); end
    x = 1'($urandom);
    in_valid = 1'b1; in_data = x;
    repeat (2) begin
      tick();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL full_stall got %b want 0", in_ready); end
    end
    chien_valid = 1'b1; chien_err = 1'b0;
    #1;
    checks++;
    if (chien_accepted !== 1'b1 || in_ready !== 1'b0)
      begin errors++; $display("FAIL full_accept got acc%b rdy%b want acc1 rdy0", chien_accepted, in_ready); end
    tick();
    chien_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL full_reopen got %b want 1", in_ready); end
    mf.push_back(1'b0);
    wq.push_back(x); md.push_back(x);
    load_data(4, 32'b0, 1'b1);
    load_flags(14, 32'b0, 1'b0);
    run_engine(1'b0, ok);
    build_exp();
    checks++;
    if (!ok) begin errors++; $display("FAIL full_timeout got stuck want drained"); end
    checks++;
    if (cap_d.size() != exp_d.size()) begin errors++; $display("FAIL full_len got %0d want %0d", cap_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
      checks++;
      if (cap_d[i] !== exp_d[i] || cap_f[i] !== exp_f[i] || cap_l[i] !== exp_l[i] ||
          (exp_l[i] && (cap_n[i] != exp_n[i] || cap_o[i] !== exp_o[i])))
        begin errors++; $display("FAIL full_bit%0d got d%b f%b l%b n%0d o%b want d%b f%b l%b n%0d o%b", i, cap_d[i], cap_f[i], cap_l[i], cap_n[i], cap_o[i], exp_d[i], exp_f[i], exp_l[i], exp_n[i], exp_o[i]); end
    end
  endtask

  task automatic test_empty_stall();
    bit ok;
    clear_all();
    chien_valid = 1'b1; chien_err = 1'b1;
    repeat (3) begin
      #1;
      checks++;
      if (chien_accepted !== 1'b0 || out_valid !== 1'b0)
        begin errors++; $display("FAIL empty_stall got acc%b v%b want acc0 v0", chien_accepted, out_valid); end
      tick();
    end
    in_valid = 1'b1; in_data = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || chien_accepted !== 1'b0)
      begin errors++; $display("FAIL empty_same_cycle got rdy%b acc%b want rdy1 acc0", in_ready, chien_accepted); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (chien_accepted !== 1'b1) begin errors++; $display("FAIL empty_next_accept got %b want 1", chien_accepted); end
    tick();
    chien_valid = 1'b0;
    md.push_back(1'b0); mf.push_back(1'b1);
    load_data(4, 32'b0, 1'b1);
    load_flags(4, 32'b0, 1'b1);
    run_engine(1'b0, ok);
    build_exp();
    checks++;
    if (!ok) begin errors++; $display("FAIL empty_timeout got stuck want drained"); end
    checks++;
    if (cap_d.size() != exp_d.size()) begin errors++; $display("FAIL empty_len got %0d want %0d", cap_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
      checks++;
      if (cap_d[i] !== exp_d[i] || cap_f[i] !== exp_f[i] || cap_l[i] !== exp_l[i] ||
          (exp_l[i] && (cap_n[i] != exp_n[i] || cap_o[i] !== exp_o[i])))
        begin errors++; $display("FAIL empty_bit%0d got d%b f%b l%b n%0d o%b want d%b f%b l%b n%0d o%b", i, cap_d[i], cap_f[i], cap_l[i], cap_n[i], cap_o[i], exp_d[i], exp_f[i], exp_l[i], exp_n[i], exp_o[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok, f0;
    clear_all();
    load_data(5, 32'b0, 1'b1);
    run_engine(1'b0, ok);
    load_flags(5, 32'b0, 1'b1);
    f0 = fq.pop_front();
    chien_valid = 1'b1; chien_err = f0;
    #1;
    checks++;
    if (chien_accepted !== 1'b1) begin errors++; $display("FAIL bp_first_accept got %b want 1", chien_accepted); end
    tick();
    out_ready = 1'b0; chien_err = fq[0];
    repeat (3) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== (md[0] ^ mf[0]) || chien_accepted !== 1'b0)
        begin errors++; $display("FAIL bp_hold got v%b d%b acc%b want v1 d%b acc0", out_valid, out_data, chien_accepted, md[0] ^ mf[0]); end
      tick();
    end
    run_engine(1'b0, ok);
    build_exp();
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout got stuck want drained"); end
    checks++;
    if (cap_d.size() != exp_d.size()) begin errors++; $display("FAIL bp_len got %0d want %0d", cap_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
      checks++;
      if (cap_d[i] !== exp_d[i] || cap_f[i] !== exp_f[i] || cap_l[i] !== exp_l[i] ||
          (exp_l[i] && (cap_n[i] != exp_n[i] || cap_o[i] !== exp_o[i])))
        begin errors++; $display("FAIL bp_bit%0d got d%b f%b l%b n%0d o%b want d%b f%b l%b n%0d o%b", i, cap_d[i], cap_f[i], cap_l[i], cap_n[i], cap_o[i], exp_d[i], exp_f[i], exp_l[i], exp_n[i], exp_o[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_all();
    load_data(5, 32'b0, 1'b1);
    fq.push_back(1'b1); fq.push_back(1'b1);
    run_engine(1'b0, ok);
    reset = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_nerr !== 3'd0)
      begin errors++; $display("FAIL midreset_state got v%b rdy%b n%0d want v0 rdy0 n0", out_valid, in_ready, out_nerr); end
    reset = 1'b0;
    tick();
    chien_valid = 1'b1; chien_err = 1'b0;
    #1;
    checks++;
    if (chien_accepted !== 1'b0) begin errors++; $display("FAIL midreset_empty got %b want 0", chien_accepted); end
    chien_valid = 1'b0;
    tick();
    clear_all();
    load_data(5, 32'b0, 1'b1);
    load_flags(5, 32'b0, 1'b1);
    run_engine(1'b0, ok);
    build_exp();
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_timeout got stuck want drained"); end
    checks++;
    if (cap_d.size() != exp_d.size()) begin errors++; $display("FAIL midreset_len got %0d want %0d", cap_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
      checks++;
      if (cap_d[i] !== exp_d[i] || cap_f[i] !== exp_f[i] || cap_l[i] !== exp_l[i] ||
          (exp_l[i] && (cap_n[i] != exp_n[i] || cap_o[i] !== exp_o[i])))
        begin errors++; $display("FAIL midreset_bit%0d got d%b f%b l%b n%0d o%b want d%b f%b l%b n%0d o%b", i, cap_d[i], cap_f[i], cap_l[i], cap_n[i], cap_o[i], exp_d[i], exp_f[i], exp_l[i], exp_n[i], exp_o[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    clear_all();
    load_data(8 * K, 32'b0, 1'b1);
    load_flags(8 * K, 32'b0, 1'b1);
    run_engine(1'b1, ok);
    build_exp();
    checks++;
    if (!ok) begin errors++; $display("FAIL rand_timeout got stuck want drained"); end
    checks++;
    if (cap_d.size() != exp_d.size()) begin errors++; $display("FAIL rand_len got %0d want %0d", cap_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
      checks++;
      if (cap_d[i] !== exp_d[i] || cap_f[i] !== exp_f[i] || cap_l[i] !== exp_l[i] ||
          (exp_l[i] && (cap_n[i] != exp_n[i] || cap_o[i] !== exp_o[i])))
        begin errors++; $display("FAIL rand_bit%0d got d%b f%b l%b n%0d o%b want d%b f%b l%b n%0d o%b", i, cap_d[i], cap_f[i], cap_l[i], cap_n[i], cap_o[i], exp_d[i], exp_f[i], exp_l[i], exp_n[i], exp_o[i]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full();
    test_empty_stall();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
